dda_move_sequencer: RTL and testbench
=====================================

DDA_MOVE_SEQUENCER -- requirements
Module: dda_move_sequencer

Interface
REQ-001 Parameter NAXIS, 3, number of step/dir axes driven in lockstep.
REQ-002 Parameter TICK_DIV, 100, clk cycles per DDA iteration (integer, >= 4).
REQ-003 Parameter PULSE_W, 50, step pulse high time in clk cycles (1 <= PULSE_W < TICK_DIV).
REQ-004 clk  in  1  single clock, all state on its rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 cmd_valid  in  1  move command offered.
REQ-007 cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
REQ-008 cmd_n  in  8  iteration count N, also the DDA denominator.
REQ-009 cmd_nx  in  8*NAXIS  per axis: bit7 direction, bits6:0 step magnitude; axis i at [8i+7:8i].
REQ-010 abort  in  1  software abort, level.
REQ-011 ls  in  NAXIS  limit switches, asynchronous, active-high.
REQ-012 step  out  NAXIS  step pulses.
REQ-013 dir  out  NAXIS  direction per axis.
REQ-014 busy  out  1  move in progress (RUN or DRAIN).
REQ-015 done  out  1  one-cycle completion strobe.
REQ-016 status  out  2  result of last move: 00 ok, 01 limit abort, 10 sw abort, 11 bad command.
REQ-017 iter_left  out  8  DDA iterations still to run.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; command accepted on a clk edge with cmd_valid=1 in IDLE.
REQ-019 At accept: latch N, per-axis magnitude and dir; clear accumulators, prescaler, pulse counters; iter_left=N.
REQ-020 Bad command (N=0, or any magnitude > N): IDLE->DONE, status=11, no step pulses, dir still updated.
REQ-021 Valid command: IDLE->RUN; prescaler counts 0..TICK_DIV-1 in RUN; tick when count=TICK_DIV-1 (first tick TICK_DIV cycles after accept).
REQ-022 Per tick, per axis (9-bit arithmetic): s=acc+mag; if s>=N then acc=s-N and start step pulse, else acc=s; iter_left decrements.
REQ-023 Step pulse: high for exactly PULSE_W cycles starting the cycle after the tick; N iterations yield exactly mag pulses per axis.
REQ-024 After the tick taking iter_left to 0: RUN->DRAIN; DRAIN waits until all step outputs low, then ->DONE with status=00.
REQ-025 ls synchronized by a 2-flop stage per bit; synchronized ls on any axis with nonzero magnitude while in RUN/DRAIN: force all step low next cycle, ->DONE, status=01.
REQ-026 abort=1 while in RUN/DRAIN: force step low next cycle, ->DONE, status=10; limit takes priority when both occur the same cycle.
REQ-027 DONE lasts one cycle (done=1), then ->IDLE; cmd_valid during DONE is ignored (cmd_ready=0); earliest re-accept is the cycle after done.
REQ-028 dir holds its latched value from accept until the next accepted command, including after abort.
REQ-029 status holds until the next DONE; iter_left freezes at abort.

Reset
REQ-030 rst=1 asynchronously forces IDLE, step=0, dir=0, done=0, busy=0, status=00, iter_left=0, accumulators/counters/synchronizers 0.
REQ-031 Reset mid-move abandons the move with no done strobe; after release, cmd_ready=1 on the first clk edge.

Structure
REQ-032 Shared package dda_pkg: state enumeration, status codes, magnitude/direction field widths and bit positions.
REQ-033 One sub-module dda_axis (accumulator, compare/subtract, pulse-width counter), instantiated NAXIS times; FSM, prescaler, iteration counter and synchronizers in the top.

Verification
REQ-034 TICK_DIV=4, PULSE_W=2, N=10, magnitudes 10/5/0 -> 10/5/0 pulses; done 1 cycle, status 00, 40 + drain cycles.
REQ-035 N=7, magnitudes 3/7/1, dirs 1/0/1 -> 3/7/1 pulses; dir=101 (axis0 LSB) held through and after move.
REQ-036 N=5, axis1 magnitude 6 -> no pulses, done 1 cycle after accept, status 11; N=0 likewise.
REQ-037 ls[0] raised mid-move with mag0>0 -> step all low within 3 cycles, status 01, iter_left frozen; ls[2] with mag2=0 -> ignored.
REQ-038 abort and ls asserted together -> status 01; abort alone -> status 10.
REQ-039 rst pulsed mid-RUN -> outputs reset immediately, no done; new command accepted and completes normally.

Source files
------------

// File: rtl/dda_pkg.sv
// dda_pkg: shared definitions for the DDA move sequencer.
//   state_t   - sequencer FSM states
//   status_t  - result code of the last move
//   field widths and bit positions of the per-axis command byte
package dda_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_LIMIT = 2'b01,
    ST_SW    = 2'b10,
    ST_BAD   = 2'b11
  } status_t;

  localparam int N_W     = 8;        // iteration count / DDA denominator
  localparam int FIELD_W = 8;        // one command byte per axis
  localparam int MAG_W   = 7;        // step magnitude width
  localparam int MAG_LSB = 0;        // magnitude position inside the byte
  localparam int DIR_BIT = 7;        // direction position inside the byte
  localparam int ACC_W   = N_W + 1;  // accumulator + magnitude never overflows

endpackage

// File: rtl/dda_axis.sv
// dda_axis: one DDA axis -- accumulator, compare/subtract and step pulse timer.
//   clk, rst : clock, async active-high reset
//   load     : command accepted; clear accumulator and pulse state
//   tick     : one DDA iteration this cycle
//   kill     : force step low immediately (abort / limit)
//   mag, n   : latched magnitude and denominator
//   step     : step pulse, PULSE_W cycles wide, starts the cycle after a carry
module dda_axis
  import dda_pkg::*;
#(
  parameter int PULSE_W = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             tick,
  input  logic             kill,
  input  logic [MAG_W-1:0] mag,
  input  logic [N_W-1:0]   n,
  output logic             step
);

  localparam int CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  assign sum   = acc + {{(ACC_W-MAG_W){1'b0}}, mag};
  assign carry = (sum >= {1'b0, n});

  // cnt holds the remaining high cycles after the current one; since
  // PULSE_W < TICK_DIV a pulse always ends before the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      step <= 1'b0;
    end else if (load || kill) begin
      acc  <= '0;
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      if (tick) begin
        acc <= carry ? (sum - {1'b0, n}) : sum;
      end
      if (tick && carry) begin
        step <= 1'b1;
        cnt  <= CNT_W'(PULSE_W - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        step <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dda_move_sequencer.sv
// dda_move_sequencer: runs an N-iteration DDA move on NAXIS step/dir axes.
//   clk, rst          : clock, async active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_n, cmd_nx     : iteration count; per axis {dir, magnitude[6:0]}
//   abort, ls         : software abort (level), async limit switches
//   step, dir         : step pulses and latched directions
//   busy, done        : move in progress, one-cycle completion strobe
//   status, iter_left : result of last move, iterations remaining
//
// state   | meaning
// IDLE    | waiting for a command
// RUN     | prescaler running, DDA iteration on every tick
// DRAIN   | all iterations done, waiting for the last pulses to end
// DONE    | one-cycle done strobe, status updated
module dda_move_sequencer
  import dda_pkg::*;
#(
  parameter int NAXIS    = 3,
  parameter int TICK_DIV = 100,
  parameter int PULSE_W  = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [N_W-1:0]         cmd_n,
  input  logic [FIELD_W*NAXIS-1:0] cmd_nx,
  input  logic                   abort,
  input  logic [NAXIS-1:0]       ls,
  output logic [NAXIS-1:0]       step,
  output logic [NAXIS-1:0]       dir,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [N_W-1:0]         iter_left
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  state_t  state, state_nxt;
  status_t status_q, status_nxt;

  logic [N_W-1:0]              n_q;
  logic [NAXIS-1:0][MAG_W-1:0] mag_q;
  logic [NAXIS-1:0][MAG_W-1:0] cmd_mag;
  logic [NAXIS-1:0]            cmd_dir;
  logic [NAXIS-1:0]            mag_nz;
  logic [NAXIS-1:0]            ls_s1, ls_s2;
  logic [PRESC_W-1:0]          presc;
  logic accept, moving, bad_cmd, lim_hit, sw_hit, kill, tick;

  always_comb begin
    bad_cmd = (cmd_n == '0);
    cmd_mag = '0;
    cmd_dir = '0;
    mag_nz  = '0;
    for (int i = 0; i < NAXIS; i++) begin
      cmd_mag[i] = cmd_nx[FIELD_W*i+MAG_LSB +: MAG_W];
      cmd_dir[i] = cmd_nx[FIELD_W*i+DIR_BIT];
      mag_nz[i]  = (mag_q[i] != '0);
      if ({1'b0, cmd_mag[i]} > cmd_n) bad_cmd = 1'b1;
    end
  end

  assign moving  = (state == S_RUN) || (state == S_DRAIN);
  assign accept  = (state == S_IDLE) && cmd_valid;
  // limit switches on axes that are not moving are irrelevant to this move
  assign lim_hit = moving && |(ls_s2 & mag_nz);
  assign sw_hit  = moving && abort;
  assign kill    = lim_hit || sw_hit;
  assign tick    = (state == S_RUN) && (presc == PRESC_MAX) && !kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      status_q <= ST_OK;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd) begin
            state_nxt  = S_DONE;
            status_nxt = ST_BAD;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN, S_DRAIN: begin
        if (lim_hit) begin
          state_nxt  = S_DONE;
          status_nxt = ST_LIMIT;
        end else if (sw_hit) begin
          state_nxt  = S_DONE;
          status_nxt = ST_SW;
        end else if (state == S_RUN) begin
          if (tick && (iter_left == 8'd1)) state_nxt = S_DRAIN;
        end else if (step == '0) begin
          state_nxt  = S_DONE;
          status_nxt = ST_OK;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      mag_q     <= '0;
      dir       <= '0;
      iter_left <= '0;
      presc     <= '0;
      ls_s1     <= '0;
      ls_s2     <= '0;
    end else begin
      ls_s1 <= ls;
      ls_s2 <= ls_s1;
      if (accept) begin
        n_q       <= cmd_n;
        mag_q     <= cmd_mag;
        dir       <= cmd_dir;
        iter_left <= cmd_n;
        presc     <= '0;
      end else begin
        if (tick) iter_left <= iter_left - 8'd1;
        if ((state == S_RUN) && !kill) begin
          presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NAXIS; g++) begin : g_axis
    dda_axis #(
      .PULSE_W(PULSE_W)
    ) u_axis (
      .clk (clk),
      .rst (rst),
      .load(accept),
      .tick(tick),
      .kill(kill),
      .mag (mag_q[g]),
      .n   (n_q),
      .step(step[g])
    );
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = moving;
  assign done      = (state == S_DONE);
  assign status    = status_q;

endmodule

// File: tb/tb_dda_move_sequencer.sv
// tb_dda_move_sequencer: reference model of a DDA move (closed-form pulse
// schedule), per-cycle comparison, directed scenarios and random traffic.
module tb_dda_move_sequencer;

  localparam int NAXIS = 3;
  localparam int TD    = 4;
  localparam int PW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_n = 8'd0;
  logic [23:0] cmd_nx = 24'd0;
  logic        abort = 1'b0;
  logic [2:0]  ls = 3'd0;
  logic [2:0]  step, dir;
  logic        busy, done;
  logic [1:0]  status;
  logic [7:0]  iter_left;

  always #5 clk = ~clk;

  dda_move_sequencer #(.NAXIS(NAXIS), .TICK_DIV(TD), .PULSE_W(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_nx(cmd_nx), .abort(abort), .ls(ls),
    .step(step), .dir(dir), .busy(busy), .done(done),
    .status(status), .iter_left(iter_left)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 move in progress, 2 done strobe
  int         m_mode, m_t, m_n, m_tdone;
  int         m_mag[NAXIS];
  logic [2:0] m_ls1, m_ls2;
  logic [2:0] e_step, e_dir;
  logic [1:0] e_status;
  logic [7:0] e_iter;

  // Axis carries on iteration j exactly when floor(j*mag/n) increases.
  function automatic bit pulse_at(int t, int n, int mag);
    int j;
    j = t / TD;
    if (j < 1 || j > n || (t % TD) >= PW) return 1'b0;
    return ((j * mag) / n) != (((j - 1) * mag) / n);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_n = 0; m_tdone = 0;
    for (int i = 0; i < NAXIS; i++) m_mag[i] = 0;
    m_ls1 = '0; m_ls2 = '0;
    e_step = '0; e_dir = '0; e_status = 2'b00; e_iter = 8'd0;
  endtask

  task automatic model_finish(input logic [1:0] code);
    m_mode   = 2;
    e_status = code;
    e_step   = '0;
  endtask

  task automatic model_step();
    logic [2:0] nz;
    bit bad, anymag;
    int tt;
    for (int i = 0; i < NAXIS; i++) nz[i] = (m_mag[i] != 0);
    if (m_mode == 1) begin
      m_t++;
      if ((m_ls2 & nz) != 0) model_finish(2'b01);
      else if (abort) model_finish(2'b10);
      else if (m_t == m_tdone) model_finish(2'b00);
      else begin
        tt = m_t / TD;
        if (tt > m_n) tt = m_n;
        e_iter = 8'(m_n - tt);
        for (int i = 0; i < NAXIS; i++) e_step[i] = pulse_at(m_t, m_n, m_mag[i]);
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (cmd_valid) begin
      m_n = cmd_n;
      bad = (cmd_n == 0);
      anymag = 1'b0;
      for (int i = 0; i < NAXIS; i++) begin
        m_mag[i] = int'(cmd_nx[8*i +: 7]);
        e_dir[i] = cmd_nx[8*i+7];
        if (m_mag[i] > m_n) bad = 1'b1;
        if (m_mag[i] != 0) anymag = 1'b1;
      end
      e_iter = cmd_n;
      if (bad) model_finish(2'b11);
      else begin
        m_mode  = 1;
        m_t     = 0;
        m_tdone = m_n * TD + (anymag ? PW : 0) + 1;
        e_step  = '0;
      end
    end
    m_ls2 = m_ls1;
    m_ls1 = ls;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("step", step, e_step);
      chk("dir", dir, e_dir);
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      chk("cmd_ready", cmd_ready, m_mode == 0);
      chk("status", status, e_status);
      chk("iter_left", iter_left, e_iter);
    end
  end

  // rising-edge pulse counter per axis
  int         pcnt[NAXIS];
  logic [2:0] step_prev = '0;
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NAXIS; i++) if (step[i] && !step_prev[i]) pcnt[i]++;
    step_prev = step;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic send(input int n, input logic [23:0] nx);
    int k;
    k = 0;
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) timeout_fail("send_ready");
    for (int i = 0; i < NAXIS; i++) pcnt[i] = 0;
    cmd_n = 8'(n);
    cmd_nx = nx;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) timeout_fail("wait_done");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_iter"}, iter_left, 0);
  endtask

  task automatic chk_pulses(input string tag, input int p0, input int p1, input int p2);
    chk({tag, "_pulses0"}, pcnt[0], p0);
    chk({tag, "_pulses1"}, pcnt[1], p1);
    chk({tag, "_pulses2"}, pcnt[2], p2);
  endtask

  localparam logic [23:0] CMD_A = {8'h00, 8'h05, 8'h0A};  // mags 10/5/0

  initial begin
    int k, dcnt, hold, n, m;
    logic [23:0] nx;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    chk("rst0_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // basic move: N=10, 10/5/0
    send(10, CMD_A);
    wait_done(k);
    chk("t1_latency", k, 43);
    chk("t1_status", status, 0);
    chk_pulses("t1", 10, 5, 0);
    @(negedge clk);
    chk("t1_done_width", done, 0);
    chk("t1_ready_after", cmd_ready, 1);

    // N=7, 3/7/1, dirs 1/0/1
    send(7, {8'h81, 8'h07, 8'h83});
    repeat (10) @(negedge clk);
    chk("t2_dir_mid", dir, 3'b101);
    wait_done(k);
    chk("t2_status", status, 0);
    chk_pulses("t2", 3, 7, 1);
    repeat (3) @(negedge clk);
    chk("t2_dir_after", dir, 3'b101);

    // bad commands
    send(5, {8'h00, 8'h86, 8'h00});
    wait_done(k);
    chk("t3_latency", k, 0);
    chk("t3_status", status, 3);
    @(negedge clk);
    chk_pulses("t3", 0, 0, 0);
    chk("t3_dir", dir, 3'b010);
    send(0, 24'h0);
    wait_done(k);
    chk("t3b_latency", k, 0);
    chk("t3b_status", status, 3);

    // limit on a moving axis
    send(10, CMD_A);
    repeat (15) @(negedge clk);
    ls = 3'b001;
    wait_done(k);
    chk("t4_lim_latency", k, 3);
    chk("t4_status", status, 1);
    chk("t4_iter", iter_left, 6);
    chk("t4_step", step, 0);
    repeat (5) @(negedge clk);
    chk("t4_iter_frozen", iter_left, 6);
    ls = 3'b000;
    repeat (3) @(negedge clk);

    // limit on a zero-magnitude axis is ignored
    send(10, CMD_A);
    repeat (5) @(negedge clk);
    ls = 3'b100;
    wait_done(k);
    chk("t4b_latency", k, 38);
    chk("t4b_status", status, 0);
    ls = 3'b000;
    repeat (3) @(negedge clk);

    // limit and abort effective on the same edge: limit wins
    send(10, CMD_A);
    repeat (5) @(negedge clk);
    ls = 3'b001;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    wait_done(k);
    chk("t5_latency", k, 1);
    chk("t5_status", status, 1);
    abort = 1'b0;
    ls = 3'b000;
    repeat (3) @(negedge clk);

    send(10, CMD_A);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    wait_done(k);
    chk("t5b_latency", k, 1);
    chk("t5b_status", status, 2);
    abort = 1'b0;

    // reset in the middle of a move
    send(10, CMD_A);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("t6_no_done", dcnt, 0);
    send(10, CMD_A);
    wait_done(k);
    chk("t6_latency", k, 43);
    chk("t6_status", status, 0);
    chk_pulses("t6", 10, 5, 0);

    // random traffic checked cycle by cycle against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 20));
      for (int i = 0; i < NAXIS; i++) begin
        m = int'($urandom_range(0, n));
        if ($urandom_range(0, 9) == 0) m = n + 1;
        nx[8*i +: 8] = {1'($urandom_range(0, 1)), 7'(m)};
      end
      cmd_n = 8'(n);
      cmd_nx = nx;
      abort = ($urandom_range(0, 299) == 0);
      if (hold > 0) hold--;
      else ls = 3'b000;
      if ($urandom_range(0, 299) == 0) begin
        ls = 3'($urandom_range(1, 7));
        hold = int'($urandom_range(1, 5));
      end
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    ls = 3'b000;
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
